// File: rtl/touch_event_encoder.sv
// touch_event_encoder: per-electrode debounce of the touch controller bitmap,
// conversion of debounced edges into {press, key} events, and a first-word
// fall-through event FIFO drained over a valid/ready handshake.
module touch_event_encoder #(
    parameter int unsigned NUM_CH          = 12,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [NUM_CH-1:0]               touch_status_in,
    input  logic                            touch_valid_in,
    input  logic                            event_ready_in,
    output logic                            event_valid_out,
    output logic [3:0]                      event_key_out,
    output logic                            event_press_out,
    output logic [NUM_CH-1:0]               keys_held_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_out
);

    localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = PW + 1;

    localparam logic [CW-1:0]   CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNTW-1:0] FIFO_FULL  = CNTW'(FIFO_DEPTH);

    // Debounce state
    logic [CW-1:0]      cnt [NUM_CH];
    logic [NUM_CH-1:0]  stable;
    logic [NUM_CH-1:0]  pending;
    logic [NUM_CH-1:0]  flip;

    // Encoder pick
    logic               pick_any;
    logic [3:0]         pick_idx;
    logic               pick_press;
    logic [NUM_CH-1:0]  pick_clr;

    // FIFO state
    logic [4:0]         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CNTW-1:0]    count;
    logic               fifo_full;
    logic               push;
    logic               pop;

    // Channels whose disagreement has persisted long enough to flip this edge
    always_comb begin
        flip = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            flip[i] = touch_valid_in && (touch_status_in[i] != stable[i])
                      && (cnt[i] == CNT_LAST);
        end
    end

    // Per-channel disagreement counters
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!touch_valid_in) begin
                    cnt[i] <= '0;
                end else if (touch_status_in[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Lowest-index pending channel is the next event to enqueue
    always_comb begin
        pick_any   = 1'b0;
        pick_idx   = '0;
        pick_press = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!pick_any && pending[i]) begin
                pick_any   = 1'b1;
                pick_idx   = 4'(i);
                pick_press = stable[i];
            end
        end
    end

    // Full is judged on the registered count, so a same-cycle pop frees nothing
    always_comb begin
        fifo_full = (count == FIFO_FULL);
        push      = pick_any && !fifo_full;
        pop       = (count != '0) && event_ready_in;
        pick_clr  = '0;
        if (push) begin
            pick_clr = NUM_CH'(1) << pick_idx;
        end
    end

    // Stable mask and pending mask; clear-then-toggle lets a same-edge flip
    // re-arm the channel and a flip-back cancel an unsent event
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stable  <= '0;
            pending <= '0;
        end else begin
            stable  <= stable ^ flip;
            pending <= (pending & ~pick_clr) ^ flip;
        end
    end

    // Event storage; contents are only visible while count is non-zero
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pick_press, pick_idx};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head outputs are forced to zero while empty so reset clears every output
    always_comb begin
        event_valid_out = (count != '0);
        event_key_out   = '0;
        event_press_out = 1'b0;
        if (event_valid_out) begin
            event_key_out   = fifo_mem[rd_ptr][3:0];
            event_press_out = fifo_mem[rd_ptr][4];
        end
        keys_held_out  = stable;
        fifo_count_out = count;
    end

endmodule

// File: tb/tb_touch_event_encoder.sv
// Directed bench for touch_event_encoder with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
module tb_touch_event_encoder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [11:0] touch_status_in;
    logic        touch_valid_in;
    logic        event_ready_in;
    logic        event_valid_out;
    logic [3:0]  event_key_out;
    logic        event_press_out;
    logic [11:0] keys_held_out;
    logic [2:0]  fifo_count_out;

    int checks   = 0;
    int failures = 0;

    touch_event_encoder #(
        .NUM_CH(12),
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .touch_status_in (touch_status_in),
        .touch_valid_in  (touch_valid_in),
        .event_ready_in  (event_ready_in),
        .event_valid_out (event_valid_out),
        .event_key_out   (event_key_out),
        .event_press_out (event_press_out),
        .keys_held_out   (keys_held_out),
        .fifo_count_out  (fifo_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_in          = 1'b0;
        touch_status_in = '0;
        touch_valid_in  = 1'b1;
        event_ready_in  = 1'b1;
        tick(2);
        rst_in = 1'b1;
    endtask

    task automatic check_head(input string tag, input logic v, input logic [3:0] k,
                              input logic p, input logic [2:0] c);
        check({tag, "_valid"}, 32'(event_valid_out), 32'(v));
        check({tag, "_key"},   32'(event_key_out),   32'(k));
        check({tag, "_press"}, 32'(event_press_out), 32'(p));
        check({tag, "_count"}, 32'(fifo_count_out),  32'(c));
    endtask

    logic [4:0] seen [$];
    logic [4:0] exp_order [6];

    initial begin
        do_reset();
        check_head("rst", 1'b0, 4'd0, 1'b0, 3'd0);
        check("rst_held", 32'(keys_held_out), 32'h000);

        // 1: single press
        touch_status_in = 12'h004;
        tick(3);
        check("t1_held_e2", 32'(keys_held_out), 32'h000);
        tick(1);
        check("t1_held_e3", 32'(keys_held_out), 32'h004);
        check("t1_valid_e3", 32'(event_valid_out), 32'd0);
        tick(1);
        check_head("t1_ev", 1'b1, 4'd2, 1'b1, 3'd1);
        tick(1);
        check_head("t1_empty", 1'b0, 4'd0, 1'b0, 3'd0);

        // 2: glitch shorter than debounce window
        do_reset();
        touch_status_in = 12'h004;
        tick(3);
        touch_status_in = 12'h000;
        tick(3);
        check("t2_held", 32'(keys_held_out), 32'h000);
        check("t2_valid", 32'(event_valid_out), 32'd0);
        touch_status_in = 12'h004;
        tick(3);
        check("t2_restart", 32'(keys_held_out), 32'h000);
        tick(1);
        check("t2_flip", 32'(keys_held_out), 32'h004);

        // 3: three simultaneous presses drain lowest first
        do_reset();
        touch_status_in = 12'h821;
        tick(4);
        check("t3_held", 32'(keys_held_out), 32'h821);
        tick(1);
        check_head("t3_k0", 1'b1, 4'd0, 1'b1, 3'd1);
        tick(1);
        check_head("t3_k5", 1'b1, 4'd5, 1'b1, 3'd1);
        tick(1);
        check_head("t3_k11", 1'b1, 4'd11, 1'b1, 3'd1);
        tick(1);
        check_head("t3_empty", 1'b0, 4'd0, 1'b0, 3'd0);

        // 4: backpressure with six edges into a four-deep FIFO
        do_reset();
        event_ready_in  = 1'b0;
        touch_status_in = 12'h007;
        tick(4);
        touch_status_in = 12'h000;
        tick(4);
        check("t4_held", 32'(keys_held_out), 32'h000);
        tick(4);
        check_head("t4_full", 1'b1, 4'd0, 1'b1, 3'd4);
        tick(3);
        check_head("t4_hold", 1'b1, 4'd0, 1'b1, 3'd4);
        exp_order = '{5'h10, 5'h11, 5'h12, 5'h00, 5'h01, 5'h02};
        event_ready_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (event_valid_out) seen.push_back({event_press_out, event_key_out});
            tick(1);
        end
        check("t4_n_events", 32'(seen.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t4_ev%0d", i),
                  (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
        end
        check_head("t4_drained", 1'b0, 4'd0, 1'b0, 3'd0);

        // 5: valid drop mid-debounce restarts the count
        do_reset();
        touch_status_in = 12'h004;
        tick(3);
        touch_valid_in = 1'b0;
        tick(1);
        check("t5_hold_invalid", 32'(keys_held_out), 32'h000);
        touch_valid_in = 1'b1;
        tick(3);
        check("t5_not_yet", 32'(keys_held_out), 32'h000);
        tick(1);
        check("t5_flip", 32'(keys_held_out), 32'h004);

        // 6: asynchronous reset mid-stream
        do_reset();
        event_ready_in  = 1'b0;
        touch_status_in = 12'h007;
        tick(7);
        check_head("t6_pre", 1'b1, 4'd0, 1'b1, 3'd3);
        rst_in = 1'b0;
        #1;
        check_head("t6_rst", 1'b0, 4'd0, 1'b0, 3'd0);
        check("t6_rst_held", 32'(keys_held_out), 32'h000);
        #2;
        rst_in = 1'b1;
        tick(4);
        check("t6_reheld", 32'(keys_held_out), 32'h007);
        tick(3);
        check_head("t6_repress", 1'b1, 4'd0, 1'b1, 3'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
